// File: rtl/button_conditioner.sv
// Synchronizes, debounces and strobes the spin/up/down buttons and the mode switch.
// Define AUTO_REPEAT_EN to build the per-button up/down auto-repeat FSMs.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 2500000,
  parameter int REPEAT_PERIOD   = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic spin_btn,
  input  logic up_btn,
  input  logic down_btn,
  input  logic mode_sw,
  output logic spin,
  output logic up,
  output logic down,
  output logic mode
);

  localparam int DW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int NCH = 4;  // channel order: 0 spin, 1 up, 2 down, 3 mode

  logic [NCH-1:0]         w_raw;
  logic [NCH-1:0]         r_meta;
  logic [NCH-1:0]         r_sync;
  logic [NCH-1:0]         r_db;
  logic [NCH-1:0]         w_toggle;
  logic [2:0]             w_rise;
  logic [NCH-1:0][DW-1:0] r_dcnt;
  logic                   r_spin;
  logic                   r_up;
  logic                   r_down;

  assign w_raw  = {mode_sw, down_btn, up_btn, spin_btn};
  assign w_rise = w_toggle[2:0] & ~r_db[2:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= w_raw;
      r_sync <= r_meta;
    end
  end

  always_comb begin
    w_toggle = '0;
    for (int i = 0; i < NCH; i++) begin
      w_toggle[i] = (r_sync[i] != r_db[i]) && (r_dcnt[i] == DW'(DEBOUNCE_CYCLES - 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dcnt <= '0;
      r_db   <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (r_sync[i] == r_db[i]) begin
          r_dcnt[i] <= '0;
        end else if (w_toggle[i]) begin
          r_dcnt[i] <= '0;
          r_db[i]   <= ~r_db[i];
        end else begin
          r_dcnt[i] <= r_dcnt[i] + DW'(1);
        end
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_t;

  logic [2:1] w_fall;
  logic [2:1] w_rep_hit;
  logic       w_both;

  assign w_fall = w_toggle[2:1] & r_db[2:1];
  assign w_both = r_db[1] & r_db[2];

  for (genvar j = 1; j <= 2; j++) begin : g_rep
    rep_state_t    r_state;
    rep_state_t    w_state_nxt;
    logic [RW-1:0] r_rcnt;
    logic [RW-1:0] w_rcnt_nxt;
    logic          w_hit;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= ST_IDLE;
        r_rcnt  <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_rcnt  <= w_rcnt_nxt;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_rcnt_nxt  = '0;
      case (r_state)
        ST_IDLE: begin
          if (w_rise[j]) w_state_nxt = ST_DELAY;
          else           w_state_nxt = ST_IDLE;
        end
        ST_DELAY: begin
          if (w_fall[j])                             w_state_nxt = ST_IDLE;
          else if (r_rcnt == RW'(REPEAT_DELAY - 1))  w_state_nxt = ST_REPEAT;
          else                                       w_rcnt_nxt  = r_rcnt + RW'(1);
        end
        ST_REPEAT: begin
          if (w_fall[j])                             w_state_nxt = ST_IDLE;
          else if (r_rcnt == RW'(REPEAT_PERIOD - 1)) w_rcnt_nxt  = '0;
          else                                       w_rcnt_nxt  = r_rcnt + RW'(1);
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end

    always_comb begin
      w_hit = 1'b0;
      case (r_state)
        ST_DELAY:  w_hit = !w_fall[j] && (r_rcnt == RW'(REPEAT_DELAY - 1));
        ST_REPEAT: w_hit = !w_fall[j] && (r_rcnt == RW'(REPEAT_PERIOD - 1));
        default:   w_hit = 1'b0;
      endcase
    end

    assign w_rep_hit[j] = w_hit;
  end

  // Repeats are masked while both up and down are held; initial presses never are.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spin <= 1'b0;
      r_up   <= 1'b0;
      r_down <= 1'b0;
    end else begin
      r_spin <= w_rise[0];
      r_up   <= w_rise[1] | (w_rep_hit[1] & ~w_both);
      r_down <= w_rise[2] | (w_rep_hit[2] & ~w_both);
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spin <= 1'b0;
      r_up   <= 1'b0;
      r_down <= 1'b0;
    end else begin
      r_spin <= w_rise[0];
      r_up   <= w_rise[1];
      r_down <= w_rise[2];
    end
  end
`endif

  assign spin = r_spin;
  assign up   = r_up;
  assign down = r_down;
  assign mode = r_db[3];

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: expected strobe cycles are queued at stimulus
// time and matched against observed strobes; repeat expectations follow AUTO_REPEAT_EN.
module tb_button_conditioner;

`ifdef AUTO_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic spin_btn;
  logic up_btn;
  logic down_btn;
  logic mode_sw;
  logic spin;
  logic up;
  logic down;
  logic mode;

  int unsigned cyc = 0;
  int unsigned q_spin[$];
  int unsigned q_up[$];
  int unsigned q_down[$];
  int n_checks = 0;
  int n_passed = 0;
  int n_failed = 0;

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (5)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .spin_btn(spin_btn),
    .up_btn  (up_btn),
    .down_btn(down_btn),
    .mode_sw (mode_sw),
    .spin    (spin),
    .up      (up),
    .down    (down),
    .mode    (mode)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_passed++;
    else begin
      n_failed++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard: any strobe, or any expected-but-absent strobe, is one comparison.
  always @(posedge clk) begin
    logic e_s;
    logic e_u;
    logic e_d;
    #1;
    e_s = (q_spin.size() != 0) && (q_spin[0] == cyc);
    e_u = (q_up.size()   != 0) && (q_up[0]   == cyc);
    e_d = (q_down.size() != 0) && (q_down[0] == cyc);
    if (spin === 1'b1 || e_s) begin
      chk("spin_strobe", 32'(spin), 32'(e_s));
      if (e_s) void'(q_spin.pop_front());
    end
    if (up === 1'b1 || e_u) begin
      chk("up_strobe", 32'(up), 32'(e_u));
      if (e_u) void'(q_up.pop_front());
    end
    if (down === 1'b1 || e_d) begin
      chk("down_strobe", 32'(down), 32'(e_d));
      if (e_d) void'(q_down.pop_front());
    end
  end

  initial begin
    int unsigned k;
    rst_n    = 1'b0;
    spin_btn = 1'b0;
    up_btn   = 1'b0;
    down_btn = 1'b0;
    mode_sw  = 1'b0;

    // 1. reset and idle
    for (int i = 0; i < 5; i++) begin
      wait_cyc(1);
      chk("reset_outputs", 32'({spin, up, down, mode}), 32'h0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      wait_cyc(1);
      chk("idle_outputs", 32'({spin, up, down, mode}), 32'h0);
    end

    // 2. glitch rejection, then a clean spin press
    spin_btn = 1'b1;
    wait_cyc(3);
    spin_btn = 1'b0;
    wait_cyc(20);
    k = cyc;
    spin_btn = 1'b1;
    q_spin.push_back(k + 6);
    wait_cyc(40);
    spin_btn = 1'b0;
    wait_cyc(20);

    // 3. up held 50 cycles
    k = cyc;
    up_btn = 1'b1;
    q_up.push_back(k + 6);
    if (REP) begin
      for (int unsigned t = 26; t <= 51; t += 5) q_up.push_back(k + t);
    end
    wait_cyc(50);
    up_btn = 1'b0;
    wait_cyc(20);

    // 4. up, then down 10 cycles later, both held; down released first
    k = cyc;
    up_btn = 1'b1;
    q_up.push_back(k + 6);
    wait_cyc(10);
    down_btn = 1'b1;
    q_down.push_back(k + 16);
    wait_cyc(60);
    down_btn = 1'b0;
    if (REP) begin
      for (int unsigned t = 81; t <= 101; t += 5) q_up.push_back(k + t);
    end
    wait_cyc(30);
    up_btn = 1'b0;
    wait_cyc(20);

    // 5a. mode level
    mode_sw = 1'b1;
    wait_cyc(5);
    chk("mode_before", 32'(mode), 32'h0);
    wait_cyc(1);
    chk("mode_after", 32'(mode), 32'h1);
    wait_cyc(5);

    // 5b. reset while up is repeating
    k = cyc;
    up_btn = 1'b1;
    q_up.push_back(k + 6);
    if (REP) begin
      q_up.push_back(k + 26);
      q_up.push_back(k + 31);
    end
    wait_cyc(33);
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", 32'({spin, up, down, mode}), 32'h0);
    for (int i = 0; i < 3; i++) begin
      wait_cyc(1);
      chk("midreset_hold", 32'({spin, up, down, mode}), 32'h0);
    end
    k = cyc;
    rst_n = 1'b1;
    q_up.push_back(k + 6);
    wait_cyc(5);
    chk("mode_post_reset_low", 32'(mode), 32'h0);
    wait_cyc(1);
    chk("mode_post_reset_high", 32'(mode), 32'h1);
    wait_cyc(4);
    up_btn = 1'b0;
    wait_cyc(20);

    // 6. down held 50 cycles
    k = cyc;
    down_btn = 1'b1;
    q_down.push_back(k + 6);
    if (REP) begin
      for (int unsigned t = 26; t <= 51; t += 5) q_down.push_back(k + t);
    end
    wait_cyc(50);
    down_btn = 1'b0;
    wait_cyc(20);

    chk("spin_queue_drained", q_spin.size(), 32'h0);
    chk("up_queue_drained", q_up.size(), 32'h0);
    chk("down_queue_drained", q_down.size(), 32'h0);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
